// File: rtl/sys_cont_fsm2.sv
// Result-return controller: captures a register read (1 byte) or ALU result (2 bytes)
// and hands it to the UART transmitter byte by byte, with timeout and drop detection.
module sys_cont_fsm2 #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic               clck,
    input  logic               rst,
    input  logic               fsm2_start,
    input  logic [WIDTH-1:0]   RdData,
    input  logic               RD_data_valid,
    input  logic [2*WIDTH-1:0] ALU_OUT,
    input  logic               ALU_OUT_valid,
    input  logic               tx_busy,
    output logic [WIDTH-1:0]   TX_P_DATA,
    output logic               TX_D_VALID,
    output logic               fsm2_busy,
    output logic               timeout_err,
    output logic               drop_err
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WAIT_RES  = 3'd1;
    localparam logic [2:0] LOAD      = 3'd2;
    localparam logic [2:0] WAIT_ACC  = 3'd3;
    localparam logic [2:0] WAIT_DONE = 3'd4;

    logic [2:0]         state,      state_d;
    logic [2*WIDTH-1:0] result_buf, result_buf_d;
    logic               two_byte,   two_byte_d;
    logic               byte_idx,   byte_idx_d;
    logic [CW-1:0]      cnt,        cnt_d;
    logic [WIDTH-1:0]   tx_data_q,  tx_data_d;
    logic               busy_q;
    logic               tmo_q,      tmo_d;
    logic               drop_q,     drop_d;

    logic               any_valid;
    logic               both_valid;
    logic               capture;
    logic [2*WIDTH-1:0] cap_buf;
    logic [WIDTH-1:0]   cap_low;

    assign any_valid  = RD_data_valid | ALU_OUT_valid;
    assign both_valid = RD_data_valid & ALU_OUT_valid;

    // Read data has priority; a read only replaces the low half of the buffer.
    assign cap_buf = RD_data_valid ? {result_buf[2*WIDTH-1:WIDTH], RdData} : ALU_OUT;
    assign cap_low = RD_data_valid ? RdData : ALU_OUT[WIDTH-1:0];

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave
        // it unassigned and infer a latch.
        state_d      = state;
        result_buf_d = result_buf;
        two_byte_d   = two_byte;
        byte_idx_d   = byte_idx;
        cnt_d        = cnt;
        tx_data_d    = tx_data_q;
        tmo_d        = 1'b0;
        drop_d       = 1'b0;
        capture      = 1'b0;

        case (state)
            IDLE: begin
                if (fsm2_start) begin
                    if (any_valid) begin
                        capture = 1'b1;
                        state_d = LOAD;
                    end else begin
                        state_d = WAIT_RES;
                        cnt_d   = '0;
                    end
                end
            end

            WAIT_RES: begin
                if (any_valid) begin
                    capture = 1'b1;
                    state_d = LOAD;
                end else if (cnt == CNT_LAST) begin
                    state_d = IDLE;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end

            LOAD: begin
                drop_d = any_valid;
                // No timeout here: a busy transmitter is still finishing a prior frame.
                if (!tx_busy) begin
                    state_d = WAIT_ACC;
                    cnt_d   = '0;
                end
            end

            WAIT_ACC: begin
                drop_d = any_valid;
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt == CNT_LAST) begin
                    state_d = IDLE;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end

            WAIT_DONE: begin
                drop_d = any_valid;
                if (!tx_busy) begin
                    if (two_byte && !byte_idx) begin
                        byte_idx_d = 1'b1;
                        tx_data_d  = result_buf[2*WIDTH-1:WIDTH];
                        state_d    = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        if (capture) begin
            result_buf_d = cap_buf;
            two_byte_d   = !RD_data_valid;
            byte_idx_d   = 1'b0;
            tx_data_d    = cap_low;
            drop_d       = both_valid;
        end
    end

    always_ff @(posedge clck) begin
        // NOTE: state registers use non-blocking assignments so every flop samples the
        // pre-edge values, independent of statement order.
        if (rst) begin
            state       <= IDLE;
            result_buf  <= '0;
            two_byte    <= 1'b0;
            byte_idx    <= 1'b0;
            cnt         <= '0;
            tx_data_q   <= '0;
            busy_q      <= 1'b0;
            tmo_q       <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state       <= state_d;
            result_buf  <= result_buf_d;
            two_byte    <= two_byte_d;
            byte_idx    <= byte_idx_d;
            cnt         <= cnt_d;
            tx_data_q   <= tx_data_d;
            busy_q      <= (state_d != IDLE);
            tmo_q       <= tmo_d;
            drop_q      <= drop_d;
        end
    end

    assign TX_P_DATA   = tx_data_q;
    assign TX_D_VALID  = (state == LOAD) && !tx_busy;
    assign fsm2_busy   = busy_q;
    assign timeout_err = tmo_q;
    assign drop_err    = drop_q;

endmodule

// File: tb/tb_sys_cont_fsm2.sv
// Self-checking bench for sys_cont_fsm2: directed vector table, randomized transactions
// against a transaction-level model, and a reset-mid-transfer sequence.
module tb_sys_cont_fsm2;

    localparam int TIMEOUT = 16;
    localparam int BIG     = 1 << 30;
    localparam int BUDGET  = 200;
    localparam int N_RAND  = 40;

    logic        clck = 1'b0;
    logic        rst;
    logic        fsm2_start;
    logic [7:0]  RdData;
    logic        RD_data_valid;
    logic [15:0] ALU_OUT;
    logic        ALU_OUT_valid;
    logic        tx_busy;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VALID;
    logic        fsm2_busy;
    logic        timeout_err;
    logic        drop_err;

    sys_cont_fsm2 #(.WIDTH(8), .TIMEOUT(TIMEOUT)) dut (
        .clck          (clck),
        .rst           (rst),
        .fsm2_start    (fsm2_start),
        .RdData        (RdData),
        .RD_data_valid (RD_data_valid),
        .ALU_OUT       (ALU_OUT),
        .ALU_OUT_valid (ALU_OUT_valid),
        .tx_busy       (tx_busy),
        .TX_P_DATA     (TX_P_DATA),
        .TX_D_VALID    (TX_D_VALID),
        .fsm2_busy     (fsm2_busy),
        .timeout_err   (timeout_err),
        .drop_err      (drop_err)
    );

    always #5 clck = ~clck;

    // kind: 0 start only, 1 register read, 2 ALU result, 3 both strobes together.
    // drop_mode: 0 none, 1 extra strobe in LOAD, 2 extra strobe while the TX is busy.
    typedef struct {
        int          kind;
        logic [7:0]  rd;
        logic [15:0] alu;
        int          res_delay;
        int          tx_delay;
        int          tx_len;
        int          drop_mode;
        int          exp_nbytes;
        logic [7:0]  exp_b0;
        logic [7:0]  exp_b1;
        int          exp_drops;
        int          exp_tmo;
    } vec_t;

    int n_total = 0;
    int n_bad   = 0;

    // Transmitter model and observation state, in cycles counted from the start of a test.
    int         step_k;
    int         busy_from;
    int         busy_to;
    int         cur_delay;
    int         cur_len;
    logic [7:0] obs_q[$];
    int         m_first_load;
    int         m_load2;
    int         m_bt1;
    int         m_tmo_k;
    int         m_drop;
    int         m_tmo;
    logic       m_busy;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit busy_at(input int c);
        return (c >= busy_from) && (c <= busy_to);
    endfunction

    // One clock cycle: inputs already set by the caller at the falling edge.
    task automatic step();
        tx_busy = busy_at(step_k);
        #1;
        if (TX_D_VALID === 1'b1) begin
            obs_q.push_back(TX_P_DATA);
            if (obs_q.size() == 1) m_first_load = step_k;
            if (obs_q.size() == 2) begin
                m_load2 = step_k;
                m_bt1   = busy_to;
            end
            busy_from = step_k + 1 + cur_delay;
            busy_to   = busy_from + cur_len - 1;
        end
        if (drop_err === 1'b1) m_drop++;
        if (timeout_err === 1'b1) begin
            m_tmo++;
            m_tmo_k = step_k;
        end
        m_busy = fsm2_busy;
        @(posedge clck);
        step_k++;
        @(negedge clck);
    endtask

    task automatic clear_monitor();
        obs_q.delete();
        step_k       = 0;
        busy_from    = BIG;
        busy_to      = -1;
        m_first_load = -1;
        m_load2      = -1;
        m_bt1        = -1;
        m_tmo_k      = -1;
        m_drop       = 0;
        m_tmo        = 0;
    endtask

    function automatic vec_t mk(input int kind, input logic [7:0] rd, input logic [15:0] alu,
                                input int rdly, input int txd, input int len, input int dm,
                                input int nb, input logic [7:0] b0, input logic [7:0] b1,
                                input int drops, input int tmo);
        vec_t v;
        v.kind = kind; v.rd = rd; v.alu = alu; v.res_delay = rdly; v.tx_delay = txd;
        v.tx_len = len; v.drop_mode = dm; v.exp_nbytes = nb; v.exp_b0 = b0; v.exp_b1 = b1;
        v.exp_drops = drops; v.exp_tmo = tmo;
        return v;
    endfunction

    // Transaction-level reference: what bytes go out and which error pulses occur.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        bit got   = (v.kind != 0) && (v.res_delay <= TIMEOUT);
        bit stall = (v.tx_delay >= TIMEOUT);
        r.exp_b0 = 8'h00;
        r.exp_b1 = 8'h00;
        if (!got) begin
            r.exp_nbytes = 0;
            r.exp_drops  = 0;
            r.exp_tmo    = 1;
        end else begin
            if (v.kind == 2) begin
                r.exp_b0     = v.alu[7:0];
                r.exp_b1     = v.alu[15:8];
                r.exp_nbytes = stall ? 1 : 2;
            end else begin
                r.exp_b0     = v.rd;
                r.exp_nbytes = 1;
            end
            r.exp_drops = ((v.kind == 3) ? 1 : 0) +
                          (((v.drop_mode == 1) || (v.drop_mode == 2 && !stall)) ? 1 : 0);
            r.exp_tmo   = stall ? 1 : 0;
        end
        return r;
    endfunction

    task automatic run_txn(input vec_t v, input int id);
        bit    done     = 1'b0;
        bit    injected = 1'b0;
        bit    captured = (v.kind != 0) && (v.res_delay <= TIMEOUT);
        int    end_k    = -1;
        int    load1_k  = v.res_delay + 1;
        string p        = $sformatf("v%0d", id);

        clear_monitor();
        cur_delay = v.tx_delay;
        cur_len   = v.tx_len;
        for (int k = 0; k < BUDGET && !done; k++) begin
            fsm2_start    = (k == 0);
            RD_data_valid = 1'b0;
            ALU_OUT_valid = 1'b0;
            RdData        = 8'($urandom);
            ALU_OUT       = 16'($urandom);
            if (v.kind != 0 && k == v.res_delay) begin
                RdData        = v.rd;
                ALU_OUT       = v.alu;
                RD_data_valid = (v.kind == 1 || v.kind == 3);
                ALU_OUT_valid = (v.kind >= 2);
            end
            if (captured && !injected &&
                ((v.drop_mode == 1 && k == v.res_delay + 1) ||
                 (v.drop_mode == 2 && busy_at(step_k) && busy_at(step_k - 1)))) begin
                ALU_OUT_valid = 1'b1;
                ALU_OUT       = 16'hBEEF;
                injected      = 1'b1;
            end
            step();
            if (k > 0 && m_busy !== 1'b1) begin
                done  = 1'b1;
                end_k = k;
            end
        end
        fsm2_start    = 1'b0;
        RD_data_valid = 1'b0;
        ALU_OUT_valid = 1'b0;

        check({p, ".done"}, done, 1);
        check({p, ".nbytes"}, obs_q.size(), v.exp_nbytes);
        if (v.exp_nbytes >= 1)
            check({p, ".byte0"}, (obs_q.size() >= 1) ? obs_q[0] : -1, v.exp_b0);
        if (v.exp_nbytes >= 2)
            check({p, ".byte1"}, (obs_q.size() >= 2) ? obs_q[1] : -1, v.exp_b1);
        check({p, ".drops"}, m_drop, v.exp_drops);
        check({p, ".timeouts"}, m_tmo, v.exp_tmo);
        if (v.exp_nbytes >= 1)
            check({p, ".load_latency"}, m_first_load, load1_k);
        if (v.exp_nbytes == 2)
            check({p, ".load2_cycle"}, m_load2, m_bt1 + 2);
        if (v.exp_tmo != 0)
            check({p, ".timeout_cycle"}, m_tmo_k,
                  (v.exp_nbytes == 0) ? TIMEOUT + 1 : load1_k + TIMEOUT + 1);
        else
            check({p, ".end_cycle"}, end_k, busy_to + 2);
    endtask

    vec_t vecs[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit hit;

        rst = 1'b1; fsm2_start = 1'b0; RdData = '0; RD_data_valid = 1'b0;
        ALU_OUT = '0; ALU_OUT_valid = 1'b0; tx_busy = 1'b0;
        clear_monitor();
        cur_delay = 0; cur_len = 1;
        repeat (2) @(posedge clck);
        @(negedge clck);
        #1;
        check("reset.tx_d_valid", TX_D_VALID, 0);
        check("reset.tx_p_data", TX_P_DATA, 0);
        check("reset.fsm2_busy", fsm2_busy, 0);
        check("reset.timeout_err", timeout_err, 0);
        check("reset.drop_err", drop_err, 0);
        rst = 1'b0;
        @(negedge clck);

        //            kind rd     alu       rdly txd  len dm  nb b0     b1     drp tmo
        vecs[0]  = mk(1, 8'hA5, 16'h0000,  0,   0,   10, 0,  1, 8'hA5, 8'h00, 0,  0);
        vecs[1]  = mk(2, 8'h00, 16'h1234,  3,   0,   4,  0,  2, 8'h34, 8'h12, 0,  0);
        vecs[2]  = mk(0, 8'h00, 16'h0000,  0,   0,   2,  0,  0, 8'h00, 8'h00, 0,  1);
        vecs[3]  = mk(1, 8'h3C, 16'h0000,  16,  1,   2,  0,  1, 8'h3C, 8'h00, 0,  0);
        vecs[4]  = mk(2, 8'h00, 16'h5566,  17,  0,   2,  0,  0, 8'h00, 8'h00, 0,  1);
        vecs[5]  = mk(1, 8'h5A, 16'h0000,  0,   1000, 2, 0,  1, 8'h5A, 8'h00, 0,  1);
        vecs[6]  = mk(2, 8'h00, 16'hABCD,  1,   15,  2,  0,  2, 8'hCD, 8'hAB, 0,  0);
        vecs[7]  = mk(2, 8'h00, 16'h0102,  0,   16,  2,  0,  1, 8'h02, 8'h00, 0,  1);
        vecs[8]  = mk(2, 8'h00, 16'h1234,  2,   0,   5,  2,  2, 8'h34, 8'h12, 1,  0);
        vecs[9]  = mk(3, 8'h77, 16'h9988,  0,   0,   3,  0,  1, 8'h77, 8'h00, 1,  0);
        vecs[10] = mk(1, 8'h11, 16'h0000,  0,   2,   3,  1,  1, 8'h11, 8'h00, 1,  0);
        vecs[11] = mk(3, 8'hC3, 16'h4321,  5,   0,   2,  1,  1, 8'hC3, 8'h00, 2,  0);

        for (int i = 0; i < 12; i++) run_txn(vecs[i], i);

        // Reset while the first byte of an ALU result is in WAIT_DONE.
        clear_monitor();
        cur_delay = 0; cur_len = 6; hit = 1'b0;
        for (int k = 0; k < 60 && !hit; k++) begin
            fsm2_start    = (k == 0);
            ALU_OUT_valid = (k == 0);
            ALU_OUT       = 16'h1234;
            RD_data_valid = 1'b0;
            if (busy_at(step_k) && busy_at(step_k - 1)) begin
                rst           = 1'b1;
                ALU_OUT_valid = 1'b1;
                ALU_OUT       = 16'hBEEF;
                hit           = 1'b1;
            end
            step();
        end
        rst = 1'b0; fsm2_start = 1'b0; ALU_OUT_valid = 1'b0;
        busy_from = BIG; busy_to = -1; tx_busy = 1'b0;
        #1;
        check("rst_mid.reached", hit, 1);
        check("rst_mid.bytes_before", obs_q.size(), 1);
        check("rst_mid.tx_d_valid", TX_D_VALID, 0);
        check("rst_mid.tx_p_data", TX_P_DATA, 0);
        check("rst_mid.fsm2_busy", fsm2_busy, 0);
        check("rst_mid.timeout_err", timeout_err, 0);
        check("rst_mid.drop_err", drop_err, 0);
        @(negedge clck);

        for (int i = 0; i < N_RAND; i++) begin
            vec_t v;
            int   r;
            v.kind      = int'($urandom_range(0, 3));
            v.rd        = 8'($urandom);
            v.alu       = 16'($urandom);
            v.res_delay = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 18))
                                                      : int'($urandom_range(0, 5));
            r = int'($urandom_range(0, 5));
            v.tx_delay  = (r == 0) ? int'($urandom_range(14, 17)) :
                          (r == 1) ? 1000 : int'($urandom_range(0, 3));
            v.tx_len    = int'($urandom_range(2, 6));
            v.drop_mode = int'($urandom_range(0, 2));
            v = model(v);
            run_txn(v, 100 + i);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/sys_cont_fsm2.md
# sys_cont_fsm2

Result-return controller of the system-control pair. It sits directly downstream of the command-decoding controller, which asserts `fsm2_start` when a register read or ALU operation has been issued. The block captures the register-file read data (one byte) or the ALU result (two bytes), then feeds them byte by byte into the UART transmitter using that transmitter's valid/busy handshake. It also detects missing results and stalled transmitters with a timeout, and flags results that arrive while a transfer is in progress.

## Interface
- `WIDTH`, 8: byte width; register-file data width; UART TX payload width.
- `TIMEOUT`, 16: cycles allowed in a wait state before abort; must be ≥2.
- `clck`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `fsm2_start`  in  1  level from command controller; request to return a result.
- `RdData`  in  WIDTH  register-file read data.
- `RD_data_valid`  in  1  single-cycle strobe; `RdData` valid.
- `ALU_OUT`  in  2*WIDTH  ALU result.
- `ALU_OUT_valid`  in  1  single-cycle strobe; `ALU_OUT` valid.
- `tx_busy`  in  1  UART TX busy (high while a frame is shifting).
- `TX_P_DATA`  out  WIDTH  byte presented to UART TX.
- `TX_D_VALID`  out  1  one-cycle load strobe to UART TX.
- `fsm2_busy`  out  1  high whenever state ≠ IDLE.
- `timeout_err`  out  1  one-cycle pulse on timeout abort.
- `drop_err`  out  1  one-cycle pulse when a result is discarded.

## Operation
- States: IDLE, WAIT_RES, LOAD, WAIT_ACC, WAIT_DONE.
- Internal state: 2·WIDTH result buffer, 1-bit `two_byte` flag, 1-bit byte index, timeout counter of width $clog2(TIMEOUT).
- **IDLE.** Valid strobes arriving without `fsm2_start` are ignored and produce no flag.
  - `fsm2_start`=1 with a valid strobe in the same cycle: capture the result and go to LOAD.
  - `fsm2_start`=1 with no valid strobe: go to WAIT_RES and clear the counter.
- **Capture.**
  - `RD_data_valid`: buffer[WIDTH-1:0]=`RdData`, `two_byte`=0.
  - `ALU_OUT_valid`: buffer=`ALU_OUT`, `two_byte`=1.
  - Both strobes in the same cycle: the read data wins and `drop_err` pulses for the ALU result.
  - Capture always clears the byte index.
- **WAIT_RES.**
  - A valid strobe captures the result and the state goes to LOAD.
  - Otherwise the counter increments. When the counter equals TIMEOUT-1 with no strobe, go to IDLE and pulse `timeout_err`.
- **LOAD.**
  - `TX_P_DATA` = buffer low byte when the index is 0, high byte when the index is 1.
  - `TX_D_VALID` = (state==LOAD && !`tx_busy`). It is combinational from the state and `tx_busy`.
  - Once asserted, go to WAIT_ACC and clear the counter. While `tx_busy`=1, stay in LOAD with no timeout.
- **WAIT_ACC.**
  - `tx_busy`=1: go to WAIT_DONE.
  - Otherwise the counter increments. At TIMEOUT-1, go to IDLE and pulse `timeout_err`.
- **WAIT_DONE.** When `tx_busy`=0:
  - If `two_byte`=1 and the index is 0: set the index to 1 and go to LOAD.
  - Otherwise go to IDLE.
- **Byte order.** ALU results are sent low byte first, then high byte. Read results are one byte.
- **Drops.** Any valid strobe seen in LOAD, WAIT_ACC or WAIT_DONE is discarded and `drop_err` pulses. The buffer is never overwritten mid-transfer.
- `fsm2_start` is ignored outside IDLE. A level still high on return to IDLE starts a new request.

## Timing
- **Reset.** `rst`=1 at edge N → from N+1:
  - state=IDLE;
  - buffer, counter, index and `two_byte` all 0;
  - `TX_P_DATA`=0;
  - `TX_D_VALID`, `fsm2_busy`, `timeout_err` and `drop_err` all 0.
- Reset mid-transfer aborts immediately with no error pulse.
- **Registered vs combinational outputs.** `TX_P_DATA`, `fsm2_busy`, `timeout_err` and `drop_err` are registered. `TX_D_VALID` is combinational.
- **Latency.**
  - Strobe in cycle C (IDLE+start or WAIT_RES) → LOAD in C+1.
  - With `tx_busy`=0, `TX_D_VALID`=1 in C+1.
- **Data stability.** `TX_P_DATA` is stable from LOAD entry until the state leaves WAIT_DONE or advances to the next byte.
- **Timeout.** Exactly TIMEOUT cycles are spent in WAIT_RES or WAIT_ACC before abort. `timeout_err` is high in the first IDLE cycle after the abort.
- **Error pulses.** `drop_err` is high in the cycle after the offending strobe. Error pulses never exceed one cycle per event.

## Test plan
- **Register read.** `fsm2_start`+`RD_data_valid` with `RdData`=0xA5 in the same cycle; TX model: busy 10 cycles after the load.
  → one `TX_D_VALID` with `TX_P_DATA`=0xA5; `fsm2_busy` falls after busy drops; no errors.
- **ALU result.** Start, then `ALU_OUT`=0x1234 valid 3 cycles later.
  → two loads: 0x34 then 0x12, the second only after `tx_busy` falls.
- **Missing result.** Start, no result, TIMEOUT=16.
  → `timeout_err` pulse 16 cycles after WAIT_RES entry; IDLE; no `TX_D_VALID`.
- **Stalled transmitter.** `tx_busy` never rises after the load.
  → abort after 16 cycles in WAIT_ACC with `timeout_err`.
- **Drop while sending.** `ALU_OUT_valid` (0xBEEF) during WAIT_DONE of a 0x1234 transfer.
  → `drop_err` pulse; transmitted bytes remain 0x34, 0x12.
- **Simultaneous strobes and reset.**
  - Both strobes in one cycle → read data sent and `drop_err` pulses.
  - `rst` asserted in WAIT_DONE → all outputs 0 next cycle; IDLE.
